// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: one P_WIDTH/P_STAGES-bit slice per stage, carry rippling through stage registers.
// Define PIPELINED_ADDSUB_SATURATE_EN to clamp signed-overflow results to the signed extreme.
module pipelined_addsub #(
  parameter int P_WIDTH  = 32,
  parameter int P_STAGES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_WIDTH-1:0] i_a,
  input  logic [P_WIDTH-1:0] i_b,
  input  logic               i_sub,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_WIDTH-1:0] o_y,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_zero
);
  localparam int W    = P_WIDTH / P_STAGES;
  localparam int LAST = P_STAGES - 1;

  logic en;
  logic ovf_q;
  logic zero_q;

  // The whole pipe stalls only when a result is waiting and downstream refuses it.
  assign en      = !(o_valid && !i_ready);
  assign o_ready = en && i_rst_n;

  for (genvar gi = 0; gi < P_STAGES; gi++) begin : g_stage
    localparam int IN_W   = P_WIDTH - gi * W;
    localparam int DONE_W = (gi + 1) * W;

    logic              v_in;
    logic              c_in;
    logic [IN_W-1:0]   a_in;
    logic [IN_W-1:0]   b_in;
    logic [DONE_W-1:0] y_raw;
    logic [DONE_W-1:0] y_d;
    logic [DONE_W-1:0] y_q;
    logic [W:0]        sum;
    logic              c_d;
    logic              v_q;
    logic              c_q;

    if (gi == 0) begin : g_src
      assign v_in  = i_valid && o_ready;
      assign a_in  = i_a;
      assign b_in  = i_sub ? ~i_b : i_b;
      assign c_in  = i_sub;
      assign y_raw = sum[W-1:0];
    end else begin : g_src
      assign v_in  = g_stage[gi-1].v_q;
      assign a_in  = g_stage[gi-1].g_fwd.a_q;
      assign b_in  = g_stage[gi-1].g_fwd.b_q;
      assign c_in  = g_stage[gi-1].c_q;
      assign y_raw = {sum[W-1:0], g_stage[gi-1].y_q};
    end

    always_comb begin
      sum = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};
      c_d = sum[W];
    end

    if (gi < LAST) begin : g_fwd
      // Only the operand slices still to be added travel onwards.
      logic [IN_W-W-1:0] a_d;
      logic [IN_W-W-1:0] b_d;
      logic [IN_W-W-1:0] a_q;
      logic [IN_W-W-1:0] b_q;

      always_comb begin
        a_d = a_in[IN_W-1:W];
        b_d = b_in[IN_W-1:W];
      end

      always_ff @(posedge i_clk) begin
        if (en && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign y_d = y_raw;
    end else begin : g_last
      logic               ovf_d;
      logic               zero_d;
      logic [P_WIDTH-1:0] y_fin;

      always_comb begin
        ovf_d = (a_in[W-1] == b_in[W-1]) && (sum[W-1] != a_in[W-1]);
        y_fin = y_raw;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (ovf_d) begin
          y_fin = a_in[W-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
`endif
        zero_d = (y_fin == '0);
      end

      assign y_d = y_fin;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en && v_in) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end

    // Data registers load only on a real operation so bubbles leave o_y untouched.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        y_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= c_d;
          y_q <= y_d;
        end
      end
    end
  end

  assign o_valid    = g_stage[LAST].v_q;
  assign o_y        = g_stage[LAST].y_q;
  assign o_carry    = g_stage[LAST].c_q;
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;
endmodule
